pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder_pkg.sv | 11 +
 rtl/pipelined_adder_chunk.sv | 16 +
 rtl/pipelined_adder.sv | 136 +++++++++++++
 tb/tb_pipelined_adder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and helpers for the carry-skewed pipelined adder.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipelined_adder_chunk.sv
// One CW-bit slice of the skewed adder: purely combinational ripple add.
module adder_chunk
  import pipelined_adder_pkg::*;
#(
  parameter int CW = chunk_width(DEFAULT_WIDTH, DEFAULT_STAGES)
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder.sv
// Skewed pipelined adder: stage k adds chunk k, with valid/ready flow control.
// Define PIPELINED_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW   = chunk_width(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  if (WIDTH < 4 || WIDTH > 64 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be 4..64 and a multiple of STAGES");
  end

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] ch_cin;
  logic [STAGES-1:0] ch_cout;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_n [STAGES];
  logic [CW-1:0]     ch_a  [STAGES];
  logic [CW-1:0]     ch_b  [STAGES];
  logic [CW-1:0]     ch_sum[STAGES];

  // Operands travel whole; each stage only consumes its own chunk.
  always_comb begin
    ch_a[0]   = a[CW-1:0];
    ch_b[0]   = b[CW-1:0];
    ch_cin[0] = cin;
    for (int k = 1; k < STAGES; k++) begin
      ch_a[k]   = a_q[k-1][k*CW +: CW];
      ch_b[k]   = b_q[k-1][k*CW +: CW];
      ch_cin[k] = c_q[k-1];
    end
  end

  always_comb begin
    sum_n[0]         = '0;
    sum_n[0][CW-1:0] = ch_sum[0];
    for (int k = 1; k < STAGES; k++) begin
      sum_n[k]              = sum_q[k-1];
      sum_n[k][k*CW +: CW]  = ch_sum[k];
    end
  end

  // Bubble-collapsing load chain; depends only on valids and out_ready.
  always_comb begin
    ld       = '0;
    ld[LAST] = !vld_q[LAST] || out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      ld[k] = !vld_q[k] || ld[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_chunk #(.CW(CW)) u_chunk (
      .a    (ch_a[k]),
      .b    (ch_b[k]),
      .cin  (ch_cin[k]),
      .sum  (ch_sum[k]),
      .cout (ch_cout[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      if (ld[0]) begin
        vld_q[0] <= in_valid;
        a_q[0]   <= a;
        b_q[0]   <= b;
        sum_q[0] <= sum_n[0];
        c_q[0]   <= ch_cout[0];
      end
      for (int k = 1; k < STAGES; k++) begin
        if (ld[k]) begin
          vld_q[k] <= vld_q[k-1];
          a_q[k]   <= a_q[k-1];
          b_q[k]   <= b_q[k-1];
          sum_q[k] <= sum_n[k];
          c_q[k]   <= ch_cout[k];
        end
      end
    end
  end

`ifdef PIPELINED_ADDER_OVF_EN
  logic ovf_q;

  // The last chunk holds the operand MSBs, so overflow is resolved alongside the final sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (ld[LAST]) begin
      ovf_q <= (ch_a[LAST][CW-1] == ch_b[LAST][CW-1]) &&
               (ch_sum[LAST][CW-1] != ch_a[LAST][CW-1]);
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = ld[0];
  assign out_valid = vld_q[LAST];
  assign sum       = sum_q[LAST];
  assign cout      = c_q[LAST];

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=16, STAGES=4); ovf checked when PIPELINED_ADDER_OVF_EN is defined.
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             cin       = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             in_ready;
  logic             out_valid;
  logic             cout;
  logic [WIDTH-1:0] sum;
`ifdef PIPELINED_ADDER_OVF_EN
  logic             ovf;
`endif

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c);
    exp_t           r;
    logic [WIDTH:0] t;
    t      = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    r.sum  = t[WIDTH-1:0];
    r.cout = t[WIDTH];
    r.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Pops on output handshakes, pushes on input handshakes.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_out++;
        check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("out_sum", 32'(sum), 32'(e.sum));
          check("out_cout", 32'(cout), 32'(e.cout));
`ifdef PIPELINED_ADDER_OVF_EN
          check("out_ovf", 32'(ovf), 32'(e.ovf));
`endif
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, cin));
    end
  end

  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc);
    int guard;
    guard    = 0;
    a        = ta;
    b        = tb_v;
    cin      = tc;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("send_accept_timeout", 32'(guard < 50), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  logic [WIDTH-1:0] bp_a [6];
  logic [WIDTH-1:0] bp_b [6];
  logic             bp_c [6];

  initial begin
    int               lat;
    int               idx;
    int               accepts;
    int               guard;
    int               stale;
    logic             took;
    logic [WIDTH-1:0] held_sum;
    exp_t             first;

    bp_a = '{16'h1111, 16'h8001, 16'hFFFF, 16'h0F0F, 16'hABCD, 16'h7FFF};
    bp_b = '{16'h2222, 16'h8001, 16'hFFFF, 16'hF0F0, 16'h1234, 16'h7FFF};
    bp_c = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPELINED_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Latency: accepting edge counts as edge 1, out_valid after edge 4
    send(16'h0001, 16'h0002, 1'b0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    check("lat_sum", 32'(sum), 32'h0003);
    check("lat_cout", 32'(cout), 32'd0);

    // Carry rippling through every stage, and carry-in
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'h1234, 16'h4321, 1'b1);
    drain();
    check("outputs_seen_a", 32'(n_out), 32'd3);

    // Backpressure: out_ready low for six cycles
    out_ready = 1'b0;
    idx       = 0;
    accepts   = 0;
    held_sum  = '0;
    first     = model(bp_a[0], bp_b[0], bp_c[0]);
    a         = bp_a[0];
    b         = bp_b[0];
    cin       = bp_c[0];
    in_valid  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      took = in_ready;
      if (took) accepts++;
      if (c == 4) begin
        held_sum = sum;
        check("bp_valid_c4", 32'(out_valid), 32'd1);
      end
      if (c == 5) begin
        check("bp_valid_held", 32'(out_valid), 32'd1);
        check("bp_sum_held", 32'(sum), 32'(held_sum));
        check("bp_head_sum", 32'(sum), 32'(first.sum));
      end
      @(posedge clk);
      #1;
      if (took) begin
        idx++;
        if (idx < 6) begin
          a   = bp_a[idx];
          b   = bp_b[idx];
          cin = bp_c[idx];
        end
      end
    end
    check("bp_accepts", 32'(accepts), 32'd4);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    guard     = 0;
    while (idx < 6 && guard < 50) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) begin
        idx++;
        if (idx < 6) begin
          a   = bp_a[idx];
          b   = bp_b[idx];
          cin = bp_c[idx];
        end
      end
      guard++;
    end
    in_valid = 1'b0;
    check("bp_all_sent", 32'(idx), 32'd6);
    drain();
    check("outputs_seen_b", 32'(n_out), 32'd9);

    // Reset with three transactions in flight
    send(16'h0101, 16'h0202, 1'b0);
    send(16'h0303, 16'h0404, 1'b0);
    send(16'h0505, 16'h0606, 1'b1);
    @(posedge clk);
    #1;
    check("mid_rst_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_sum", 32'(sum), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale_after_rst", 32'(stale), 32'd0);
    @(posedge clk);
    #1;
    send(16'h00F0, 16'h000F, 1'b1);
    drain();
    check("outputs_seen_c", 32'(n_out), 32'd10);

`ifdef PIPELINED_ADDER_OVF_EN
    // Signed overflow cases
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    drain();
    check("outputs_seen_d", 32'(n_out), 32'd12);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
